// File: rtl/spi_ram_regfile_if.sv
// spi_ram_regfile_if
// Command/response bundle between the SPI slave and the spi_ram_regfile.
//
// Handshake: valid-only. The regfile accepts a command on every rising edge
// where i_rx_valid=1, so there is no ready signal. o_tx_valid and o_err are
// one-cycle pulses raised on the edge that samples the command. Both
// pulses are never high together.
//
// Signals:
//   i_rx_data    [DATA_WIDTH+1:0]  opcode in the top two bits, payload below
//   i_rx_valid                     command present this cycle
//   o_tx_data    [DATA_WIDTH-1:0]  last read data. It holds until the next good read.
//   o_tx_valid                     pulse: o_tx_data is new
//   o_err                          pulse: command rejected
//   o_busy                         a write or read pointer is armed
//   dbg_*                          pointer/armed state, for observation only
// Modports: master = SPI slave side, slave = regfile side.
interface spi_ram_regfile_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 8
);
    logic [DATA_WIDTH+1:0]   i_rx_data;
    logic                    i_rx_valid;
    logic [DATA_WIDTH-1:0]   o_tx_data;
    logic                    o_tx_valid;
    logic                    o_err;
    logic                    o_busy;
    logic [ADDRESS_SIZE-1:0] dbg_wr_ptr;
    logic [ADDRESS_SIZE-1:0] dbg_rd_ptr;
    logic                    dbg_wr_armed;
    logic                    dbg_rd_armed;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_tx_data, o_tx_valid, o_err, o_busy,
        input  dbg_wr_ptr, dbg_rd_ptr, dbg_wr_armed, dbg_rd_armed
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_tx_data, o_tx_valid, o_err, o_busy,
        output dbg_wr_ptr, dbg_rd_ptr, dbg_wr_armed, dbg_rd_armed
    );
endinterface

// File: rtl/spi_ram_regfile.sv
// spi_ram_regfile
// This module is the memory target behind the SPI slave. Each command word carries
// a 2-bit opcode and a payload:
//   00 write-address   01 write-data   10 read-address   11 read-data
// The module keeps separate write and read pointers. When AUTO_INC=1, each
// pointer advances after every data access and wraps to 0 at LENGTH-1.
//
// Ports:
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-high reset. It clears the outputs, the pointers,
//          the armed flags and every memory word.
//   bus    spi_ram_regfile_if.slave (see the interface for signal meanings)
module spi_ram_regfile #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDRESS_SIZE = 8,
    parameter int unsigned LENGTH       = 2 ** ADDRESS_SIZE,
    parameter bit          AUTO_INC     = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    spi_ram_regfile_if.slave   bus
);
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(LENGTH - 1);

    logic [DATA_WIDTH-1:0]   mem [LENGTH];
    logic [ADDRESS_SIZE-1:0] wr_ptr;
    logic [ADDRESS_SIZE-1:0] rd_ptr;
    logic                    wr_armed;
    logic                    rd_armed;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    err;

    logic [1:0]              opcode;
    logic [DATA_WIDTH-1:0]   payload;
    logic                    addr_ok;
    logic [ADDRESS_SIZE-1:0] wr_ptr_next;
    logic [ADDRESS_SIZE-1:0] rd_ptr_next;

    always_comb begin
        opcode  = bus.i_rx_data[DATA_WIDTH+1:DATA_WIDTH];
        payload = bus.i_rx_data[DATA_WIDTH-1:0];
        // An address must fall inside the array and must not have bits above
        // the pointer width. The second test matters when DATA_WIDTH > ADDRESS_SIZE.
        addr_ok = (32'(payload) < LENGTH) && ((payload >> ADDRESS_SIZE) == '0);
        // The wrap is taken at LENGTH-1, not at the natural pointer overflow.
        // This keeps a short array (LENGTH < 2**ADDRESS_SIZE) in range.
        wr_ptr_next = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDRESS_SIZE'(1);
        rd_ptr_next = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDRESS_SIZE'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_armed <= 1'b0;
            rd_armed <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < int'(LENGTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            if (bus.i_rx_valid) begin
                case (opcode)
                    OP_WR_ADDR: begin
                        if (addr_ok) begin
                            wr_ptr   <= payload[ADDRESS_SIZE-1:0];
                            wr_armed <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_WR_DATA: begin
                        if (wr_armed) begin
                            mem[wr_ptr] <= payload;
                            if (AUTO_INC) wr_ptr <= wr_ptr_next;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_RD_ADDR: begin
                        if (addr_ok) begin
                            rd_ptr   <= payload[ADDRESS_SIZE-1:0];
                            rd_armed <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_RD_DATA: begin
                        // Only one command is accepted per edge. A read therefore
                        // always sees writes taken on earlier edges and never
                        // collides with a write.
                        if (rd_armed) begin
                            tx_data  <= mem[rd_ptr];
                            tx_valid <= 1'b1;
                            if (AUTO_INC) rd_ptr <= rd_ptr_next;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_valid   = tx_valid;
    assign bus.o_err        = err;
    assign bus.o_busy       = wr_armed | rd_armed;
    assign bus.dbg_wr_ptr   = wr_ptr;
    assign bus.dbg_rd_ptr   = rd_ptr;
    assign bus.dbg_wr_armed = wr_armed;
    assign bus.dbg_rd_armed = rd_armed;
endmodule

// File: tb/tb_spi_ram_regfile.sv
// tb_spi_ram_regfile
// This bench drives three regfile variants from one clock and one reset:
//   dut 0: LENGTH=256, AUTO_INC=1
//   dut 1: LENGTH=200, AUTO_INC=1
//   dut 2: LENGTH=256, AUTO_INC=0
// The directed vector table lists {dut, command, expected outputs}. Each
// command is applied for one edge, and the outputs are compared 1 ns after
// that edge. Hand-written sequences then cover the idle-cycle pulse return
// and the asynchronous reset in the middle of a burst.
module tb_spi_ram_regfile;
    logic clk;
    logic rst;

    spi_ram_regfile_if #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) if_a ();
    spi_ram_regfile_if #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) if_b ();
    spi_ram_regfile_if #(.DATA_WIDTH(8), .ADDRESS_SIZE(8)) if_c ();

    spi_ram_regfile #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .LENGTH(256), .AUTO_INC(1'b1))
        u_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
    spi_ram_regfile #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .LENGTH(200), .AUTO_INC(1'b1))
        u_b (.i_clk(clk), .i_rst(rst), .bus(if_b));
    spi_ram_regfile #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .LENGTH(256), .AUTO_INC(1'b0))
        u_c (.i_clk(clk), .i_rst(rst), .bus(if_c));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [9:0] word;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_data;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic idle_all();
        if_a.i_rx_valid = 1'b0;
        if_b.i_rx_valid = 1'b0;
        if_c.i_rx_valid = 1'b0;
        if_a.i_rx_data  = '0;
        if_b.i_rx_data  = '0;
        if_c.i_rx_data  = '0;
    endtask

    // Present one command to one dut for exactly one rising edge.
    task automatic send_cmd(input int d, input logic [9:0] w);
        idle_all();
        case (d)
            0: begin if_a.i_rx_data = w; if_a.i_rx_valid = 1'b1; end
            1: begin if_b.i_rx_data = w; if_b.i_rx_valid = 1'b1; end
            default: begin if_c.i_rx_data = w; if_c.i_rx_valid = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic get_out(input int d, output logic v, output logic e,
                           output logic [7:0] data, output logic b);
        case (d)
            0: begin v = if_a.o_tx_valid; e = if_a.o_err; data = if_a.o_tx_data; b = if_a.o_busy; end
            1: begin v = if_b.o_tx_valid; e = if_b.o_err; data = if_b.o_tx_data; b = if_b.o_busy; end
            default: begin v = if_c.o_tx_valid; e = if_c.o_err; data = if_c.o_tx_data; b = if_c.o_busy; end
        endcase
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int d, input logic ev, input logic ee,
                              input logic [7:0] ed, input logic eb);
        logic v, e, b;
        logic [7:0] data;
        get_out(d, v, e, data, b);
        check_bit({tag, ".tx_valid"}, v, ev);
        check_bit({tag, ".err"}, e, ee);
        check_byte({tag, ".tx_data"}, data, ed);
        check_bit({tag, ".busy"}, b, eb);
    endtask

    task automatic add(input int d, input logic [9:0] w, input logic v, input logic e,
                       input logic [7:0] data, input logic b);
        vec_t x;
        x.dut = d; x.word = w; x.exp_valid = v; x.exp_err = e; x.exp_data = data; x.exp_busy = b;
        vecs.push_back(x);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_all();

        // dut 0: read before any read-address, then a basic single write/read
        add(0, 10'h300, 1'b0, 1'b1, 8'h00, 1'b0);
        add(0, 10'h005, 1'b0, 1'b0, 8'h00, 1'b1);
        add(0, 10'h1A5, 1'b0, 1'b0, 8'h00, 1'b1);
        add(0, 10'h205, 1'b0, 1'b0, 8'h00, 1'b1);
        add(0, 10'h300, 1'b1, 1'b0, 8'hA5, 1'b1);
        // dut 0: back-to-back burst across the FF->00 wrap
        add(0, 10'h0FE, 1'b0, 1'b0, 8'hA5, 1'b1);
        add(0, 10'h111, 1'b0, 1'b0, 8'hA5, 1'b1);
        add(0, 10'h122, 1'b0, 1'b0, 8'hA5, 1'b1);
        add(0, 10'h133, 1'b0, 1'b0, 8'hA5, 1'b1);
        add(0, 10'h2FE, 1'b0, 1'b0, 8'hA5, 1'b1);
        add(0, 10'h300, 1'b1, 1'b0, 8'h11, 1'b1);
        add(0, 10'h300, 1'b1, 1'b0, 8'h22, 1'b1);
        add(0, 10'h300, 1'b1, 1'b0, 8'h33, 1'b1);
        // dut 0: same address written then read back
        add(0, 10'h005, 1'b0, 1'b0, 8'h33, 1'b1);
        add(0, 10'h177, 1'b0, 1'b0, 8'h33, 1'b1);
        add(0, 10'h205, 1'b0, 1'b0, 8'h33, 1'b1);
        add(0, 10'h300, 1'b1, 1'b0, 8'h77, 1'b1);
        // dut 1 (LENGTH=200): out-of-range addresses, an unarmed write, wrap at 199
        add(1, 10'h0C8, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1, 10'h155, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1, 10'h2FF, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1, 10'h200, 1'b0, 1'b0, 8'h00, 1'b1);
        add(1, 10'h300, 1'b1, 1'b0, 8'h00, 1'b1);
        add(1, 10'h0C7, 1'b0, 1'b0, 8'h00, 1'b1);
        add(1, 10'h1AB, 1'b0, 1'b0, 8'h00, 1'b1);
        add(1, 10'h1CD, 1'b0, 1'b0, 8'h00, 1'b1);
        add(1, 10'h2C7, 1'b0, 1'b0, 8'h00, 1'b1);
        add(1, 10'h300, 1'b1, 1'b0, 8'hAB, 1'b1);
        add(1, 10'h300, 1'b1, 1'b0, 8'hCD, 1'b1);
        add(1, 10'h300, 1'b1, 1'b0, 8'h00, 1'b1);
        // dut 2 (AUTO_INC=0): pointers stay put
        add(2, 10'h003, 1'b0, 1'b0, 8'h00, 1'b1);
        add(2, 10'h101, 1'b0, 1'b0, 8'h00, 1'b1);
        add(2, 10'h102, 1'b0, 1'b0, 8'h00, 1'b1);
        add(2, 10'h203, 1'b0, 1'b0, 8'h00, 1'b1);
        add(2, 10'h300, 1'b1, 1'b0, 8'h02, 1'b1);
        add(2, 10'h300, 1'b1, 1'b0, 8'h02, 1'b1);
        add(2, 10'h204, 1'b0, 1'b0, 8'h02, 1'b1);
        add(2, 10'h300, 1'b1, 1'b0, 8'h00, 1'b1);

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) check_outs($sformatf("reset.d%0d", d), d, 1'b0, 1'b0, 8'h00, 1'b0);
        check_bit("reset.wr_armed", if_b.dbg_wr_armed, 1'b0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            send_cmd(vecs[i].dut, vecs[i].word);
            check_outs($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp_valid,
                       vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_busy);
        end
        check_bit("lenchk.wr_armed_b", if_b.dbg_wr_armed, 1'b1);

        // Both pulses drop on an idle cycle, and the data holds.
        send_cmd(0, 10'h003);
        send_cmd(0, 10'h1EE);
        send_cmd(0, 10'h203);
        send_cmd(0, 10'h300);
        check_outs("seq.read_ee", 0, 1'b1, 1'b0, 8'hEE, 1'b1);
        @(posedge clk);
        #1;
        check_outs("seq.idle", 0, 1'b0, 1'b0, 8'hEE, 1'b1);

        // Reset mid-burst: it takes effect without a clock edge.
        send_cmd(0, 10'h1FF);
        send_cmd(0, 10'h300);
        check_outs("seq.pre_rst", 0, 1'b1, 1'b0, 8'hFF, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("seq.async_rst", 0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_byte("seq.async_rst.wr_ptr", if_a.dbg_wr_ptr, 8'h00);
        check_byte("seq.async_rst.rd_ptr", if_a.dbg_rd_ptr, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_cmd(0, 10'h1AA);
        check_outs("seq.post_rst_wr", 0, 1'b0, 1'b1, 8'h00, 1'b0);
        send_cmd(0, 10'h203);
        send_cmd(0, 10'h300);
        check_outs("seq.post_rst_rd3", 0, 1'b1, 1'b0, 8'h00, 1'b1);
        send_cmd(0, 10'h300);
        check_outs("seq.post_rst_rd4", 0, 1'b1, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_ram_regfile.md
Name: spi_ram_regfile

Overview:
- Parametrised successor to the plain register file; sits behind the SPI slave as its memory target.
- Takes command words from the SPI slave's receive path: a 2-bit opcode plus a payload.
- Decodes each word as write-address, write-data, read-address or read-data.
- Keeps its own write and read address pointers, with optional auto-increment for burst access.
- Returns read data to the SPI slave's transmit path with a one-cycle valid pulse, and flags protocol errors.

Parameters:
- DATA_WIDTH, 8: memory word width and command payload width.
- ADDRESS_SIZE, 8: address pointer width; must be <= DATA_WIDTH.
- LENGTH, 2**ADDRESS_SIZE: number of words; must be <= 2**ADDRESS_SIZE.
- AUTO_INC, 1: 1 = the pointer increments after every data access; 0 = pointers are static.

Ports:
- i_clk, input, 1: clock; all logic on the rising edge.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_rx_data, input, DATA_WIDTH+2: [DATA_WIDTH+1:DATA_WIDTH] is the opcode, [DATA_WIDTH-1:0] is the payload.
- i_rx_valid, input, 1: i_rx_data holds a command this cycle; one command per cycle, back-to-back allowed.
- o_tx_data, output, DATA_WIDTH: read data; holds its value until the next successful read.
- o_tx_valid, output, 1: one-cycle pulse, o_tx_data is new.
- o_err, output, 1: one-cycle pulse, the command was rejected.
- o_busy, output, 1: high while a write-address or read-address pointer is armed.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - o_tx_data=0, o_tx_valid=0, o_err=0, o_busy=0.
  - wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0.
  - All LENGTH memory words cleared to 0.
  - Reset asserted mid-burst aborts the burst; no partial write survives.
- A command is sampled only on a rising edge with i_rx_valid=1; when i_rx_valid=0 nothing changes except the pulses returning to 0.
- Opcode 00, write-address:
  - If payload < LENGTH and payload[DATA_WIDTH-1:ADDRESS_SIZE]==0: wr_ptr<=payload[ADDRESS_SIZE-1:0], wr_armed<=1.
  - Otherwise o_err pulses and wr_ptr/wr_armed are unchanged.
- Opcode 01, write-data:
  - If wr_armed: mem[wr_ptr]<=payload.
  - If additionally AUTO_INC: wr_ptr<=(wr_ptr==LENGTH-1) ? 0 : wr_ptr+1, wrapping to 0.
  - If not wr_armed: o_err pulses and there is no write.
- Opcode 10, read-address: same range check as opcode 00, applied to rd_ptr/rd_armed.
- Opcode 11, read-data (payload ignored):
  - If rd_armed: o_tx_data<=mem[rd_ptr] and o_tx_valid=1 for exactly one cycle, both registered on the edge that samples the command (visible the cycle after i_rx_valid).
  - If additionally AUTO_INC: rd_ptr increments with the same wrap as wr_ptr.
  - If not rd_armed: o_err pulses, o_tx_valid stays 0 and o_tx_data is unchanged.
- Ordering: a read-data command sees every write-data command sampled on an earlier edge; there is no stale read and no read/write collision.
- Shared address: if wr_ptr==rd_ptr, consecutive write-then-read returns the new data.
- o_busy = wr_armed | rd_armed. Armed flags are cleared only by reset; once armed, a pointer stays armed.
- o_err and o_tx_valid are never both 1 in the same cycle.
- Pointer arithmetic is ADDRESS_SIZE bits wide; the wrap to 0 occurs at LENGTH-1 even when LENGTH < 2**ADDRESS_SIZE.
- Bursts of LENGTH+1 data commands revisit address 0 with no error.

Test Plan:
- Reset, then read-data opcode 11 with no read-address -> o_err pulse 1 cycle later, o_tx_valid=0, o_tx_data=0.
- Commands 0x005 (wr-addr 5), 0x1A5 (wr-data A5), 0x205 (rd-addr 5), 0x300 (rd-data) -> o_tx_data=0xA5 with o_tx_valid for 1 cycle, one cycle after the rd-data command.
- AUTO_INC=1, back-to-back: wr-addr 0xFE then data 11, 22, 33 -> mem[FE]=11, mem[FF]=22, mem[00]=33; rd-addr FE plus 3 reads -> 11, 22, 33 on 3 consecutive cycles.
- LENGTH=200, wr-addr 0xC8 -> o_err pulse, wr_armed remains 0, and a following wr-data also errors with no memory change.
- AUTO_INC=0: wr-addr 3, data 01 then 02 -> mem[3]=02 and mem[4]=0.
- i_rst asserted mid-burst between two wr-data commands -> all outputs 0 immediately without waiting for a clock; subsequent rd-addr 3 plus read returns 0x00.
